// File: rtl/mem_access.sv
// Data-memory stage: multi-cycle doubleword load/store into a local memory, branch
// resolution (pc_src) and the write-back mux for the register file.
module mem_access #(
  parameter int unsigned WORD        = 64,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_BITS   = 6,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [WORD-1:0] alu_result,
  input  logic [WORD-1:0] store_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic            branch,
  input  logic            uncond_branch,
  input  logic            zero,
  output logic            busy,
  output logic            done,
  output logic            pc_src,
  output logic [WORD-1:0] read_data,
  output logic [WORD-1:0] wb_data,
  output logic            fault
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [WORD-1:0] addr_q, addr_d, sdata_q, sdata_d;
  logic            rd_q, rd_d, wr_q, wr_d, m2r_q, m2r_d;
  logic            br_q, br_d, ub_q, ub_d, zero_q, zero_d;
  logic            busy_q, busy_d, done_q, done_d, pc_src_q, pc_src_d, fault_q, fault_d;
  logic [WORD-1:0] read_data_q, read_data_d, wb_data_q, wb_data_d;
  logic [WORD-1:0] mem_q [DEPTH];

  logic                 req_fault;
  logic                 commit;
  logic [ADDR_BITS-1:0] idx;
  logic [WORD-1:0]      mem_rdata;

  // Only requests that touch memory can fault.
  assign req_fault = (mem_read | mem_write) &
                     ((alu_result[2:0] != 3'b000) | (|alu_result[WORD-1:ADDR_BITS+3]) |
                      (mem_read & mem_write));
  assign idx       = addr_q[ADDR_BITS+2:3];
  assign mem_rdata = mem_q[idx];
  assign commit    = (state_q == StWait) && (cnt_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    m2r_d       = m2r_q;
    br_d        = br_q;
    ub_d        = ub_q;
    zero_d      = zero_q;
    pc_src_d    = pc_src_q;
    fault_d     = fault_q;
    read_data_d = read_data_q;
    wb_data_d   = wb_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = alu_result;
          sdata_d = store_data;
          rd_d    = mem_read;
          wr_d    = mem_write;
          m2r_d   = mem_to_reg;
          br_d    = branch;
          ub_d    = uncond_branch;
          zero_d  = zero;
          if ((mem_read | mem_write) && !req_fault) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES);
          end else begin
            // No memory access: results are ready for the RESP cycle right away.
            state_d   = StResp;
            pc_src_d  = uncond_branch | (branch & zero);
            fault_d   = req_fault;
            wb_data_d = mem_to_reg ? (req_fault ? '0 : read_data_q) : alu_result;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d  = StResp;
          pc_src_d = ub_q | (br_q & zero_q);
          fault_d  = 1'b0;
          if (rd_q) begin
            read_data_d = mem_rdata;
          end
          wb_data_d = m2r_q ? (rd_q ? mem_rdata : read_data_q) : addr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StResp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      m2r_q       <= 1'b0;
      br_q        <= 1'b0;
      ub_q        <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pc_src_q    <= 1'b0;
      fault_q     <= 1'b0;
      read_data_q <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      m2r_q       <= m2r_d;
      br_q        <= br_d;
      ub_q        <= ub_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pc_src_q    <= pc_src_d;
      fault_q     <= fault_d;
      read_data_q <= read_data_d;
      wb_data_q   <= wb_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit && wr_q) begin
      mem_q[idx] <= sdata_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pc_src    = pc_src_q;
  assign fault     = fault_q;
  assign read_data = read_data_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: scoreboard of expected responses built from a
// small reference model of the memory stage.
module tb_mem_access;

  localparam int unsigned Wait = 2;

  typedef struct packed {
    logic [7:0]  lat;
    logic        pc;
    logic [63:0] wb;
    logic        flt;
    logic [63:0] rd;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset, start, mem_read, mem_write, mem_to_reg, branch, uncond_branch, zero;
  logic [63:0] alu_result, store_data;
  logic        busy, done, pc_src, fault;
  logic [63:0] read_data, wb_data;

  int    errors = 0;
  int    checks = 0;
  resp_t sb[$];
  logic [63:0] mdl_mem [64];
  logic [63:0] mdl_rd;

  mem_access #(
    .WORD       (64),
    .DEPTH      (64),
    .ADDR_BITS  (6),
    .WAIT_CYCLES(Wait)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .branch       (branch),
    .uncond_branch(uncond_branch),
    .zero         (zero),
    .busy         (busy),
    .done         (done),
    .pc_src       (pc_src),
    .read_data    (read_data),
    .wb_data      (wb_data),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
    mdl_rd = '0;
  endfunction

  // Expected response of one request; updates the model memory and read_data.
  function automatic resp_t model(input logic [63:0] a, sd, input logic rd, wr, m2r, br, ub,
                                  z);
    resp_t r;
    logic  flt, acc;
    flt = (rd | wr) && ((a[2:0] != 3'b000) || (a[63:9] != '0) || (rd && wr));
    acc = (rd | wr) && !flt;
    if (acc && wr) mdl_mem[a[8:3]] = sd;
    if (acc && rd) mdl_rd = mdl_mem[a[8:3]];
    r.lat = acc ? 8'(Wait + 2) : 8'd1;
    r.pc  = ub | (br & z);
    r.flt = flt;
    r.rd  = mdl_rd;
    r.wb  = m2r ? (flt ? 64'd0 : mdl_rd) : a;
    return r;
  endfunction

  task automatic clear_inputs();
    start = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
    branch = 0; uncond_branch = 0; zero = 0; alu_result = '0; store_data = '0;
  endtask

  task automatic drive(input logic [63:0] a, sd, input logic rd, wr, m2r, br, ub, z);
    alu_result = a; store_data = sd; mem_read = rd; mem_write = wr;
    mem_to_reg = m2r; branch = br; uncond_branch = ub; zero = z; start = 1;
  endtask

  // Issues one request and waits (bounded) for done; lat counts samples from the start edge.
  task automatic issue(input logic [63:0] a, sd, input logic rd, wr, m2r, br, ub, z,
                       output resp_t got, output int bcnt);
    int lat;
    @(posedge clk); #1;
    drive(a, sd, rd, wr, m2r, br, ub, z);
    @(posedge clk); #1;
    clear_inputs();
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    got.lat = 8'(lat);
    got.pc  = pc_src;
    got.wb  = wb_data;
    got.flt = fault;
    got.rd  = read_data;
  endtask

  task automatic req(input string name, input logic [63:0] a, sd,
                     input logic rd, wr, m2r, br, ub, z);
    resp_t got, e;
    int    bcnt;
    sb.push_back(model(a, sd, rd, wr, m2r, br, ub, z));
    issue(a, sd, rd, wr, m2r, br, ub, z, got, bcnt);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got lat=%0d pc=%0b wb=%h flt=%0b rd=%h, expected lat=%0d pc=%0b wb=%h flt=%0b rd=%h",
               name, got.lat, got.pc, got.wb, got.flt, got.rd, e.lat, e.pc, e.wb, e.flt, e.rd);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    drive(64'd16, 64'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    clear_inputs();
    model_reset();
    checks++;
    if ({busy, done, pc_src, fault, read_data, wb_data} !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%0b done=%0b pc=%0b flt=%0b rd=%h wb=%h, expected all 0",
               busy, done, pc_src, fault, read_data, wb_data);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrides_start: got busy=%0b, expected 0", busy);
    end
  endtask

  task automatic test_store_load();
    resp_t got, e;
    int    bcnt;
    req("store_16", 64'd16, 64'd1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(model(64'd16, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(64'd16, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, got, bcnt);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL load_16: got lat=%0d wb=%h rd=%h flt=%0b, expected lat=%0d wb=%h rd=%h flt=%0b",
               got.lat, got.wb, got.rd, got.flt, e.lat, e.wb, e.rd, e.flt);
    end
    checks++;
    if (bcnt !== Wait + 1) begin
      errors++;
      $display("FAIL load_busy_cycles: got %0d, expected %0d", bcnt, Wait + 1);
    end
  endtask

  task automatic test_passthrough_branch();
    req("rtype_30", 64'd30, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    req("cbz_taken", 64'd100, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    req("cbz_not_taken", 64'd101, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    req("b_uncond", 64'd102, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    req("rtype_m2r", 64'd7, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_faults();
    req("fault_misaligned", 64'd20, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    req("fault_out_of_range", 64'd512, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    req("fault_rd_and_wr", 64'd16, 64'd999, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    req("store_misaligned", 64'd41, 64'd888, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    req("load_after_faults", 64'd16, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    req("load_word_top", 64'd504, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    drive(64'd40, 64'd77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    clear_inputs();
    repeat (Wait) begin
      @(posedge clk); #1;
    end
    reset = 1;  // the next edge would commit the store
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    checks++;
    if ({busy, done, pc_src, fault, read_data, wb_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%0b done=%0b pc=%0b flt=%0b rd=%h wb=%h, expected all 0",
               busy, done, pc_src, fault, read_data, wb_data);
    end
    req("load_w5_after_reset", 64'd40, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    req("load_w2_after_reset", 64'd16, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    resp_t got, e;
    int    ndone;
    sb.push_back(model(64'd8, 64'd55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    drive(64'd8, 64'd55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    clear_inputs();
    // A start while busy must be ignored.
    drive(64'd99, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ndone = 0;
    got   = '0;
    for (int i = 1; i <= 12; i++) begin
      if (done) begin
        ndone++;
        got.lat = 8'(i);
        got.pc  = pc_src;
        got.wb  = wb_data;
        got.flt = fault;
        got.rd  = read_data;
      end
      @(posedge clk); #1;
      clear_inputs();
    end
    e = sb.pop_front();
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL busy_start_done_count: got %0d, expected 1", ndone);
    end
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL busy_start_resp: got lat=%0d pc=%0b wb=%h, expected lat=%0d pc=%0b wb=%h",
               got.lat, got.pc, got.wb, e.lat, e.pc, e.wb);
    end
    req("b2b_load_8", 64'd8, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    req("b2b_store_0", 64'd0, 64'hdead_beef_0123_4567, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    req("b2b_load_0", 64'd0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    req("b2b_rtype", 64'd3, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_passthrough_branch();
    test_faults();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
